// File: rtl/ceyloniac_pc_ctrl_if.sv
// Control/status bundle between the CEYLONIACX control FSM and the PC unit.
// The master drives the strobes, and the slave (the PC unit) returns PC and RAS status.
interface ceyloniac_pc_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                pc_enable;
  logic                pc_write;
  logic [1:0]          pc_sel;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] pc_offset;
  logic                pc_call;
  logic                pc_exc;
  logic                pc_eret;
  logic [PC_WIDTH-1:0] pc_out;
  logic [PC_WIDTH-1:0] pc_next_seq;
  logic [PC_WIDTH-1:0] pc_epc;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_err;

  modport master (
    output pc_enable, pc_write, pc_sel, pc_in, pc_offset, pc_call, pc_exc, pc_eret,
    input  pc_out, pc_next_seq, pc_epc, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  pc_enable, pc_write, pc_sel, pc_in, pc_offset, pc_call, pc_exc, pc_eret,
    output pc_out, pc_next_seq, pc_epc, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/ceyloniac_pc_ctrl.sv
// Program-counter unit: next-PC select (seq/branch/jump/return), a circular return-address
// stack, and exception entry/return through an EPC register.
module ceyloniac_pc_ctrl #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter int unsigned         PC_STEP      = 1,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'('h80),
  parameter int unsigned         RAS_DEPTH    = 4,
  parameter int unsigned         RAS_PTR_W    = 2
) (
  input logic                  clk,
  input logic                  pc_reset,
  ceyloniac_pc_ctrl_if.slave   bus
);

  localparam int unsigned          CNT_W   = RAS_PTR_W + 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [RAS_PTR_W-1:0] PTR_ONE = RAS_PTR_W'(1);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_RET = 2'b11
  } sel_e;

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  epc_q, epc_d;
  logic [PC_WIDTH-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ptr_q, ptr_d, ptr_pop, wr_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_pop;
  logic                 empty_q, full_q, err_q, err_d;
  logic                 push;
  logic [PC_WIDTH-1:0]  seq_c;
  sel_e                 sel;

  assign seq_c = pc_q + PC_WIDTH'(PC_STEP);
  assign sel   = sel_e'(bus.pc_sel);

  // Next-state: exception beats eret beats write; a return pops before any call pushes.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push    = 1'b0;
    ptr_pop = ptr_q;
    cnt_pop = cnt_q;
    wr_idx  = ptr_q;
    if (bus.pc_enable) begin
      if (bus.pc_exc) begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
      end else if (bus.pc_eret) begin
        pc_d = epc_q;
      end else if (bus.pc_write) begin
        case (sel)
          SEL_SEQ: pc_d = seq_c;
          SEL_BR:  pc_d = pc_q + bus.pc_offset;
          SEL_JMP: pc_d = bus.pc_in;
          SEL_RET: begin
            if (cnt_q != '0) begin
              pc_d    = ras_mem[ptr_q];
              ptr_pop = ptr_q - PTR_ONE;
              cnt_pop = cnt_q - CNT_ONE;
            end else begin
              pc_d  = seq_c;
              err_d = 1'b1;
            end
          end
          default: pc_d = pc_q;
        endcase
        ptr_d = ptr_pop;
        cnt_d = cnt_pop;
        if (bus.pc_call) begin
          push   = 1'b1;
          wr_idx = ptr_pop + PTR_ONE;
          ptr_d  = wr_idx;
          cnt_d  = (cnt_pop == CNT_MAX) ? CNT_MAX : cnt_pop + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_MAX);
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_idx] <= seq_c;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_next_seq = seq_c;
  assign bus.pc_epc      = epc_q;
  assign bus.ras_empty   = empty_q;
  assign bus.ras_full    = full_q;
  assign bus.ras_err     = err_q;

endmodule

// File: tb/tb_ceyloniac_pc_ctrl.sv
// Self-checking bench for ceyloniac_pc_ctrl: directed scenarios plus random traffic
// against a queue-based reference model of the PC, EPC and return stack.
module tb_ceyloniac_pc_ctrl;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic pc_reset;
  int   n_checks;
  int   n_errors;

  ceyloniac_pc_ctrl_if #(.PC_WIDTH(W)) bus ();

  ceyloniac_pc_ctrl #(
    .PC_WIDTH    (W),
    .PC_STEP     (1),
    .RESET_VECTOR(32'h0),
    .EXC_VECTOR  (32'h80),
    .RAS_DEPTH   (DEPTH),
    .RAS_PTR_W   (2)
  ) dut (
    .clk     (clk),
    .pc_reset(pc_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_epc;
  logic [W-1:0] m_ras[$];
  logic         m_err;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_epc = '0;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit wr, input logic [1:0] sel,
                            input logic [W-1:0] tin, input logic [W-1:0] toff,
                            input bit call, input bit exc, input bit eret);
    logic [W-1:0] seq;
    m_err = 1'b0;
    if (!en) return;
    seq = m_pc + 32'd1;
    if (exc) begin
      m_epc = m_pc;
      m_pc  = 32'h80;
    end else if (eret) begin
      m_pc = m_epc;
    end else if (wr) begin
      case (sel)
        2'b00: m_pc = seq;
        2'b01: m_pc = m_pc + toff;
        2'b10: m_pc = tin;
        default: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            m_pc  = seq;
            m_err = 1'b1;
          end
        end
      endcase
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    bus.pc_out,      m_pc);
    chk({tag, ".seq"},   bus.pc_next_seq, m_pc + 32'd1);
    chk({tag, ".epc"},   bus.pc_epc,      m_epc);
    chk({tag, ".empty"}, W'(bus.ras_empty), W'(m_ras.size() == 0));
    chk({tag, ".full"},  W'(bus.ras_full),  W'(m_ras.size() == DEPTH));
    chk({tag, ".err"},   W'(bus.ras_err),   W'(m_err));
  endtask

  task automatic step(input string tag, input bit en, input bit wr, input logic [1:0] sel,
                      input logic [W-1:0] tin, input logic [W-1:0] toff,
                      input bit call, input bit exc, input bit eret);
    bus.pc_enable = en;
    bus.pc_write  = wr;
    bus.pc_sel    = sel;
    bus.pc_in     = tin;
    bus.pc_offset = toff;
    bus.pc_call   = call;
    bus.pc_exc    = exc;
    bus.pc_eret   = eret;
    model_step(en, wr, sel, tin, toff, call, exc, eret);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted away from any clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    #2;
    pc_reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    pc_reset = 1'b1;
  endtask

  initial begin
    logic [1:0]   sel;
    logic [W-1:0] tin;
    n_checks = 0;
    n_errors = 0;
    pc_reset = 1'b0;
    bus.pc_enable = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 2'b00;
    bus.pc_in     = '0;
    bus.pc_offset = '0;
    bus.pc_call   = 1'b0;
    bus.pc_exc    = 1'b0;
    bus.pc_eret   = 1'b0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    pc_reset = 1'b1;

    // Count to 7, then reset mid-operation
    for (int i = 0; i < 7; i++) step("cnt7", 1, 1, 2'b00, '0, '0, 0, 0, 0);
    chk("cnt7.pc", bus.pc_out, 32'd7);
    async_reset("rst_mid");
    chk("rst_mid.pc", bus.pc_out, 32'd0);

    // Sequential then hold
    for (int i = 0; i < 5; i++) step("seq", 1, 1, 2'b00, '0, '0, 0, 0, 0);
    chk("seq5.pc", bus.pc_out, 32'd5);
    step("hold", 0, 1, 2'b00, '0, '0, 1, 0, 0);
    step("hold", 0, 1, 2'b10, 32'h99, '0, 0, 1, 0);
    chk("hold.pc", bus.pc_out, 32'd5);

    // Branch, jump, wrap-around
    step("jmp10", 1, 1, 2'b10, 32'd10, '0, 0, 0, 0);
    step("br_m3", 1, 1, 2'b01, '0, 32'hFFFF_FFFD, 0, 0, 0);
    chk("br_m3.pc", bus.pc_out, 32'd7);
    step("jmp40", 1, 1, 2'b10, 32'h40, '0, 0, 0, 0);
    chk("jmp40.pc", bus.pc_out, 32'h40);
    step("jmpmax", 1, 1, 2'b10, 32'hFFFF_FFFF, '0, 0, 0, 0);
    step("wrap", 1, 1, 2'b00, '0, '0, 0, 0, 0);
    chk("wrap.pc", bus.pc_out, 32'd0);

    // Call/return
    step("jmp3", 1, 1, 2'b10, 32'd3, '0, 0, 0, 0);
    step("call", 1, 1, 2'b10, 32'h20, '0, 1, 0, 0);
    chk("call.pc", bus.pc_out, 32'h20);
    step("nowr_call", 1, 0, 2'b00, '0, '0, 1, 0, 0);
    step("ret", 1, 1, 2'b11, '0, '0, 0, 0, 0);
    chk("ret.pc", bus.pc_out, 32'd4);
    chk("ret.empty", W'(bus.ras_empty), 32'd1);

    // RAS overflow, drain, and underflow
    for (int i = 0; i < 5; i++) step("push5", 1, 1, 2'b00, '0, '0, 1, 0, 0);
    chk("push5.full", W'(bus.ras_full), 32'd1);
    for (int i = 0; i < 4; i++) step("pop4", 1, 1, 2'b11, '0, '0, 0, 0, 0);
    chk("pop4.pc", bus.pc_out, 32'd6);
    step("pop_empty", 1, 1, 2'b11, '0, '0, 0, 0, 0);
    chk("pop_empty.pc", bus.pc_out, 32'd7);
    chk("pop_empty.err", W'(bus.ras_err), 32'd1);
    step("err_clr", 0, 0, 2'b00, '0, '0, 0, 0, 0);
    chk("err_clr.err", W'(bus.ras_err), 32'd0);
    step("retcall_e", 1, 1, 2'b11, '0, '0, 1, 0, 0);
    step("push", 1, 1, 2'b10, 32'h50, '0, 1, 0, 0);
    step("retcall", 1, 1, 2'b11, '0, '0, 1, 0, 0);

    // Exception entry and return
    step("jmp12", 1, 1, 2'b10, 32'h12, '0, 0, 0, 0);
    step("exc", 1, 1, 2'b10, 32'h77, '0, 1, 1, 1);
    chk("exc.pc", bus.pc_out, 32'h80);
    chk("exc.epc", bus.pc_epc, 32'h12);
    step("eret", 1, 1, 2'b00, '0, '0, 1, 0, 1);
    chk("eret.pc", bus.pc_out, 32'h12);

    // Random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      sel = 2'($urandom_range(0, 3));
      tin = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      step("rnd", $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80, sel, tin,
           32'($signed(8'($urandom))), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4);
      if (i == 700) async_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
